id_stage_fwd: RTL and testbench

- Parametrised decode-stage front end for the in-order MIPS pipeline. Sits between IF and the decoder/EX, and contains:
  - the IF→ID pipeline register;
  - a stall-safe hold buffer for the synchronous instruction SRAM;
  - N-source operand forwarding;
  - load-use hazard detection;
  - a saturating stall-cycle counter.
- Replaces the fixed three-source, single-load-cycle decode front end.

---
 rtl/id_stage_fwd_pkg.sv | 23 ++
 rtl/id_stage_fwd_fwd_sel.sv | 47 ++++
 rtl/id_stage_fwd.sv | 132 +++++++++++++
 tb/tb_id_stage_fwd.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_fwd_pkg.sv
// Shared constants for the decode-stage front end.
// Stall-bus bit positions, NOP word, instruction field positions and
// packed-bus slicing helper for the per-source forwarding buses.
package id_stage_fwd_pkg;

  // Positions of the ID and EX bits on the pipeline stall bus
  localparam int STALL_ID_BIT = 1;
  localparam int STALL_EX_BIT = 2;

  // Canonical bubble instruction (sll $0,$0,0)
  localparam logic [31:0] NOP_INST = 32'h0;

  // Register-file address width and MIPS rs/rt field positions
  localparam int RF_AW_DEF = 5;
  localparam int RS_LSB    = 21;
  localparam int RT_LSB    = 16;

  // Low bit of source idx within a packed bus of w-bit lanes
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/id_stage_fwd_fwd_sel.sv
// Priority forwarding mux for one operand: youngest matching source wins.
// Register $0 always reads as zero regardless of any source writing it.
// Also flags a load in the load-use window that targets this operand.
module id_fwd_sel
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = RF_AW_DEF,
  parameter int NUM_FWD   = 3,
  parameter int LU_STAGES = 1
) (
  input  logic [RF_AW-1:0]          raddr,
  input  logic                      uses,
  input  logic [DATA_W-1:0]         rf_rdata,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic [DATA_W-1:0]         rdata,
  output logic                      load_hit
);

  // Scan oldest to youngest so the lowest matching index is written last
  always_comb begin
    rdata = rf_rdata;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i] && (fwd_waddr[slice_lo(i, RF_AW) +: RF_AW] == raddr)) begin
        rdata = fwd_wdata[slice_lo(i, DATA_W) +: DATA_W];
      end
    end
    if (raddr == '0) begin
      rdata = '0;
    end
  end

  // A load still inside the load-use window cannot supply its data in time
  always_comb begin
    load_hit = 1'b0;
    for (int i = 0; i < LU_STAGES; i++) begin
      if (uses && (raddr != '0) && fwd_we[i] && fwd_is_load[i] &&
          (fwd_waddr[slice_lo(i, RF_AW) +: RF_AW] == raddr)) begin
        load_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode-stage front end: IF->ID register, SRAM hold buffer, forwarding,
// load-use detection and a saturating stall counter.
// Flush beats stall; a stall with EX moving inserts a bubble into ID.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int RF_AW     = RF_AW_DEF,
  parameter int NUM_FWD   = 3,
  parameter int LU_STAGES = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_id,
  input  logic                      stall_ex,
  input  logic                      flush,
  input  logic                      if_valid,
  input  logic [PC_W-1:0]           if_pc,
  input  logic [DATA_W-1:0]         inst_sram_rdata,
  input  logic                      uses_rs,
  input  logic                      uses_rt,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic [NUM_FWD*RF_AW-1:0]  fwd_waddr,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
  output logic                      id_valid,
  output logic [PC_W-1:0]           id_pc,
  output logic [DATA_W-1:0]         id_inst,
  output logic [RF_AW-1:0]          rf_raddr1,
  output logic [RF_AW-1:0]          rf_raddr2,
  output logic [DATA_W-1:0]         id_rs_data,
  output logic [DATA_W-1:0]         id_rt_data,
  output logic                      stallreq_id,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic              hold_vld;
  logic [DATA_W-1:0] inst_hold;
  logic              rs_load_hit;
  logic              rt_load_hit;

  // IF->ID register with hold buffer; the SRAM word is only on the bus for
  // one cycle after the fetch, so the first stalled edge snapshots it
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      hold_vld  <= 1'b0;
      inst_hold <= '0;
    end else if (flush) begin
      valid_q  <= 1'b0;
      hold_vld <= 1'b0;
    end else if (stall_id && !stall_ex) begin
      valid_q  <= 1'b0;
      hold_vld <= 1'b0;
    end else if (stall_id) begin
      if (!hold_vld && valid_q) begin
        inst_hold <= inst_sram_rdata;
        hold_vld  <= 1'b1;
      end
    end else begin
      valid_q  <= if_valid;
      pc_q     <= if_pc;
      hold_vld <= 1'b0;
    end
  end

  // Present the held word during multi-cycle stalls, NOP when empty
  always_comb begin
    id_inst = DATA_W'(NOP_INST);
    if (valid_q) begin
      id_inst = hold_vld ? inst_hold : inst_sram_rdata;
    end
  end

  assign id_valid  = valid_q;
  assign id_pc     = pc_q;
  assign rf_raddr1 = id_inst[RS_LSB +: RF_AW];
  assign rf_raddr2 = id_inst[RT_LSB +: RF_AW];

  id_fwd_sel #(
    .DATA_W    (DATA_W),
    .RF_AW     (RF_AW),
    .NUM_FWD   (NUM_FWD),
    .LU_STAGES (LU_STAGES)
  ) u_fwd_rs (
    .raddr       (rf_raddr1),
    .uses        (uses_rs),
    .rf_rdata    (rf_rdata1),
    .fwd_we      (fwd_we),
    .fwd_is_load (fwd_is_load),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .rdata       (id_rs_data),
    .load_hit    (rs_load_hit)
  );

  id_fwd_sel #(
    .DATA_W    (DATA_W),
    .RF_AW     (RF_AW),
    .NUM_FWD   (NUM_FWD),
    .LU_STAGES (LU_STAGES)
  ) u_fwd_rt (
    .raddr       (rf_raddr2),
    .uses        (uses_rt),
    .rf_rdata    (rf_rdata2),
    .fwd_we      (fwd_we),
    .fwd_is_load (fwd_is_load),
    .fwd_waddr   (fwd_waddr),
    .fwd_wdata   (fwd_wdata),
    .rdata       (id_rt_data),
    .load_hit    (rt_load_hit)
  );

  assign stallreq_id = valid_q && (rs_load_hit || rt_load_hit);

  // Saturating count of load-use stall cycles; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stallreq_id && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Self-checking bench for id_stage_fwd: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the ID slot, forwarding rules and stall counter.
module tb_id_stage_fwd;
  localparam int DW = 32, PW = 32, AW = 5, NF = 3, LU = 1, CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall_id, stall_ex, flush, if_valid, uses_rs, uses_rt;
  logic [PW-1:0] if_pc;
  logic [DW-1:0] inst_sram_rdata, rf_rdata1, rf_rdata2;
  logic          we [NF];
  logic          ld [NF];
  logic [AW-1:0] wa [NF];
  logic [DW-1:0] wd [NF];
  logic [NF-1:0]    fwd_we, fwd_is_load;
  logic [NF*AW-1:0] fwd_waddr;
  logic [NF*DW-1:0] fwd_wdata;

  logic          id_valid, stallreq_id;
  logic [PW-1:0] id_pc;
  logic [DW-1:0] id_inst, id_rs_data, id_rt_data;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [CW-1:0] stall_cnt;

  always_comb begin
    fwd_we = '0; fwd_is_load = '0; fwd_waddr = '0; fwd_wdata = '0;
    for (int i = 0; i < NF; i++) begin
      fwd_we[i] = we[i];
      fwd_is_load[i] = ld[i];
      fwd_waddr[i*AW +: AW] = wa[i];
      fwd_wdata[i*DW +: DW] = wd[i];
    end
  end

  id_stage_fwd #(.DATA_W(DW), .PC_W(PW), .RF_AW(AW), .NUM_FWD(NF),
                 .LU_STAGES(LU), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush(flush), .if_valid(if_valid), .if_pc(if_pc),
    .inst_sram_rdata(inst_sram_rdata), .uses_rs(uses_rs), .uses_rt(uses_rt),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .fwd_we(fwd_we),
    .fwd_is_load(fwd_is_load), .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .stallreq_id(stallreq_id), .stall_cnt(stall_cnt)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  // Model of the ID slot: is it live, its PC, and whether its word was saved
  bit          m_valid = 0;
  logic [31:0] m_pc = '0;
  bit          m_have = 0;
  logic [31:0] m_word = '0;
  int          m_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_inst();
    if (!m_valid) return 32'h0;
    return m_have ? m_word : inst_sram_rdata;
  endfunction

  function automatic logic [31:0] fwd_model(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'h0;
    for (int i = 0; i < NF; i++)
      if (we[i] && wa[i] == r) return wd[i];
    return rf;
  endfunction

  function automatic bit exp_stall();
    logic [31:0] ei;
    logic [4:0] rs, rt;
    ei = exp_inst();
    rs = ei[25:21];
    rt = ei[20:16];
    if (!m_valid) return 1'b0;
    for (int i = 0; i < LU; i++)
      if (we[i] && ld[i] && ((uses_rs && rs != 0 && wa[i] == rs) ||
                             (uses_rt && rt != 0 && wa[i] == rt)))
        return 1'b1;
    return 1'b0;
  endfunction

  // One clock: compare at negedge, then advance the model over the edge
  task automatic cyc();
    logic [31:0] ei, nw, np;
    bit sr, nv, nh;
    int nc;
    @(negedge clk);
    ei = exp_inst();
    sr = exp_stall();
    if (chk_en) begin
      chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
      chk("id_pc", id_pc, m_pc);
      chk("id_inst", id_inst, ei);
      chk("rf_raddr1", {27'b0, rf_raddr1}, {27'b0, ei[25:21]});
      chk("rf_raddr2", {27'b0, rf_raddr2}, {27'b0, ei[20:16]});
      chk("id_rs_data", id_rs_data, fwd_model(ei[25:21], rf_rdata1));
      chk("id_rt_data", id_rt_data, fwd_model(ei[20:16], rf_rdata2));
      chk("stallreq_id", {31'b0, stallreq_id}, {31'b0, sr});
      chk("stall_cnt", {28'b0, stall_cnt}, m_cnt);
    end
    nv = m_valid; np = m_pc; nh = m_have; nw = m_word; nc = m_cnt;
    if (rst) begin
      nv = 0; np = '0; nh = 0; nc = 0;
    end else begin
      if (sr && nc < CNT_MAX) nc = nc + 1;
      if (flush || (stall_id && !stall_ex)) begin
        nv = 0; nh = 0;
      end else if (stall_id) begin
        if (m_valid && !m_have) begin nh = 1; nw = inst_sram_rdata; end
      end else begin
        nv = if_valid; np = if_pc; nh = 0;
      end
    end
    @(posedge clk);
    m_valid = nv; m_pc = np; m_have = nh; m_word = nw; m_cnt = nc;
    #1;
  endtask

  task automatic quiet();
    rst = 0; stall_id = 0; stall_ex = 0; flush = 0; uses_rs = 0; uses_rt = 0;
    for (int i = 0; i < NF; i++) begin we[i] = 0; ld[i] = 0; wa[i] = '0; wd[i] = '0; end
  endtask

  task automatic rand_inputs();
    logic [31:0] w;
    rst      = ($urandom_range(0, 63) == 0);
    flush    = ($urandom_range(0, 15) == 0);
    stall_id = ($urandom_range(0, 3) == 0);
    stall_ex = $urandom_range(0, 1) == 1;
    if_valid = $urandom_range(0, 3) != 0;
    if_pc    = $urandom;
    w = $urandom;
    w[25:21] = 5'($urandom_range(0, 7));
    w[20:16] = 5'($urandom_range(0, 7));
    inst_sram_rdata = w;
    uses_rs = $urandom_range(0, 1) == 1;
    uses_rt = $urandom_range(0, 1) == 1;
    rf_rdata1 = $urandom;
    rf_rdata2 = $urandom;
    for (int i = 0; i < NF; i++) begin
      we[i] = $urandom_range(0, 1) == 1;
      ld[i] = $urandom_range(0, 1) == 1;
      wa[i] = 5'($urandom_range(0, 7));
      wd[i] = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    quiet();
    rst = 1; if_valid = 1; if_pc = 32'h100; inst_sram_rdata = '0;
    rf_rdata1 = 32'hAAAA; rf_rdata2 = 32'hBBBB;
    // Reset held two cycles with a valid fetch presented
    cyc(); cyc(); #1;
    chk("rst id_valid", {31'b0, id_valid}, 32'h0);
    chk("rst id_inst", id_inst, 32'h0);
    chk("rst stall_cnt", {28'b0, stall_cnt}, 32'h0);
    chk_en = 1;
    rst = 0; if_pc = 32'hBFC00000;
    cyc();
    inst_sram_rdata = 32'h24010005; #1;
    chk("first id_pc", id_pc, 32'hBFC00000);
    chk("first id_inst", id_inst, 32'h24010005);

    // Multi-cycle hold while the SRAM output moves on
    stall_id = 1; stall_ex = 1; if_pc = 32'hBFC00004;
    for (int k = 0; k < 3; k++) begin
      cyc();
      inst_sram_rdata = 32'hDEADBEEF; #1;
      chk("held id_inst", id_inst, 32'h24010005);
    end
    stall_id = 0; stall_ex = 0;
    cyc();
    inst_sram_rdata = 32'h3C1D8000; #1;
    chk("after hold id_pc", id_pc, 32'hBFC00004);
    chk("after hold id_inst", id_inst, 32'h3C1D8000);

    // Bubble from stall_id with EX moving
    stall_id = 1;
    cyc();
    stall_id = 0; #1;
    chk("bubble id_valid", {31'b0, id_valid}, 32'h0);
    chk("bubble id_inst", id_inst, 32'h0);
    cyc();
    // Flush overrides a full hold
    flush = 1; stall_id = 1; stall_ex = 1;
    cyc();
    quiet(); #1;
    chk("flush id_valid", {31'b0, id_valid}, 32'h0);
    cyc();

    // Forward priority: EX and WB both write $8, MEM writes $9
    inst_sram_rdata = 32'h01090000;
    we[0] = 1; wa[0] = 5'd8; wd[0] = 32'h11;
    we[1] = 1; wa[1] = 5'd9; wd[1] = 32'h22;
    we[2] = 1; wa[2] = 5'd8; wd[2] = 32'h33;
    #1;
    chk("fwd prio rs", id_rs_data, 32'h11);
    chk("fwd mem rt", id_rt_data, 32'h22);
    inst_sram_rdata = 32'h00090000; wa[0] = 5'd0; wd[0] = 32'h55; #1;
    chk("fwd zero rs", id_rs_data, 32'h0);
    cyc();

    // Load-use: EX load to $8, ID reads rt=$8
    quiet();
    inst_sram_rdata = 32'h00080000; uses_rt = 1;
    we[0] = 1; ld[0] = 1; wa[0] = 5'd8; wd[0] = 32'h77;
    stall_id = 1; stall_ex = 1; #1;
    chk("lu stallreq", {31'b0, stallreq_id}, 32'h1);
    cyc();
    we[0] = 0; ld[0] = 0;
    we[1] = 1; ld[1] = 1; wa[1] = 5'd8; wd[1] = 32'h99;
    stall_id = 0; stall_ex = 0; inst_sram_rdata = 32'hFFFFFFFF; #1;
    chk("lu mem stallreq", {31'b0, stallreq_id}, 32'h0);
    chk("lu mem rt_data", id_rt_data, 32'h99);
    chk("lu cnt", {28'b0, stall_cnt}, 32'h1);
    uses_rt = 0; we[0] = 1; ld[0] = 1; wa[0] = 5'd8; #1;
    chk("lu no use", {31'b0, stallreq_id}, 32'h0);
    cyc();

    // Saturation: hold the hazard 20 cycles
    quiet();
    inst_sram_rdata = 32'h00080000; uses_rt = 1;
    we[0] = 1; ld[0] = 1; wa[0] = 5'd8;
    stall_id = 1; stall_ex = 1;
    repeat (20) cyc();
    #1;
    chk("sat cnt", {28'b0, stall_cnt}, 32'd15);
    cyc(); #1;
    chk("sat hold cnt", {28'b0, stall_cnt}, 32'd15);
    flush = 1;
    cyc();
    flush = 0; #1;
    chk("flush keeps cnt", {28'b0, stall_cnt}, 32'd15);
    rst = 1;
    cyc();
    quiet(); #1;
    chk("rst clears cnt", {28'b0, stall_cnt}, 32'd0);
    if_valid = 1; if_pc = 32'h400;
    cyc();
    inst_sram_rdata = 32'h12345678; #1;
    chk("no stale hold", id_inst, 32'h12345678);

    // Randomized traffic against the model
    repeat (3000) begin
      rand_inputs();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
